// File: rtl/range_bucket_counter_pkg.sv
// Shared types and constants for the range bucket counter: FSM state encoding,
// default parameter values and the bucket-index width helper.
package range_bucket_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH    = 16;
  localparam int DEF_NBUCKETS = 6;
  localparam int DEF_WRAP_W   = 8;

  // The bucket index counts 0..nbuckets inclusive, hence the +1.
  function automatic int idx_width(input int nbuckets);
    return $clog2(nbuckets + 1);
  endfunction

endpackage

// File: rtl/range_bucket_counter_if.sv
// Control/status bundle of the range bucket counter. The master drives control
// and configuration; the slave (the counter) returns count, bucket and status.
interface range_bucket_counter_if
  import range_bucket_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int NBUCKETS = DEF_NBUCKETS,
  parameter int WRAP_W   = DEF_WRAP_W
);
  localparam int IDX_W = idx_width(NBUCKETS);

  logic                      start;
  logic                      clear;
  logic                      enable;
  logic                      wrap_mode;
  logic [WIDTH-1:0]          limit;
  logic [NBUCKETS*WIDTH-1:0] thr;
  logic [WIDTH-1:0]          count;
  logic [IDX_W-1:0]          bucket;
  logic                      busy;
  logic                      done;
  logic [WRAP_W-1:0]         wraps;

  modport master (
    output start, clear, enable, wrap_mode, limit, thr,
    input  count, bucket, busy, done, wraps
  );

  modport slave (
    input  start, clear, enable, wrap_mode, limit, thr,
    output count, bucket, busy, done, wraps
  );

endinterface

// File: rtl/range_bucket_counter_threshold_bucketizer.sv
// Combinational classifier: counts how many thresholds the value has reached.
// Works for unsorted thresholds; the parent registers the result.
module threshold_bucketizer
  import range_bucket_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int NBUCKETS = DEF_NBUCKETS
) (
  input  logic [WIDTH-1:0]                   count_i,
  input  logic [NBUCKETS*WIDTH-1:0]          thr_i,
  output logic [idx_width(NBUCKETS)-1:0]     bucket_o
);
  localparam int IDX_W = idx_width(NBUCKETS);

  logic [NBUCKETS-1:0] ge_s;
  logic [IDX_W-1:0]    sum_s;

  // One unsigned comparator per threshold.
  always_comb begin
    ge_s = {NBUCKETS{1'b0}};
    for (int i = 0; i < NBUCKETS; i++) begin
      ge_s[i] = (count_i >= thr_i[i*WIDTH +: WIDTH]);
    end
  end

  // Population count of the comparator hits.
  always_comb begin
    sum_s = {IDX_W{1'b0}};
    for (int i = 0; i < NBUCKETS; i++) begin
      sum_s = sum_s + IDX_W'(ge_s[i]);
    end
  end

  assign bucket_o = sum_s;

endmodule

// File: rtl/range_bucket_counter.sv
// Programmable-limit progress counter with start/clear/enable FSM, stop or wrap
// terminal behaviour, saturating wrap-event count and registered range decode.
module range_bucket_counter
  import range_bucket_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int NBUCKETS = DEF_NBUCKETS,
  parameter int WRAP_W   = DEF_WRAP_W
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  range_bucket_counter_if.slave ctl_io
);
  localparam int IDX_W = idx_width(NBUCKETS);

  state_e            state_q,  state_d;
  logic [WIDTH-1:0]  count_q,  count_d;
  logic [WIDTH-1:0]  limit_q,  limit_d;
  logic              wrap_q,   wrap_d;
  logic [WRAP_W-1:0] wraps_q,  wraps_d;
  logic [IDX_W-1:0]  bucket_q, bucket_d;
  logic              busy_q,   busy_d;
  logic              done_q,   done_d;

  threshold_bucketizer #(
    .WIDTH    (WIDTH),
    .NBUCKETS (NBUCKETS)
  ) u_bucketizer (
    .count_i  (count_q),
    .thr_i    (ctl_io.thr),
    .bucket_o (bucket_d)
  );

  // Next-state and datapath decode; clear beats start beats enable.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    limit_d = limit_q;
    wrap_d  = wrap_q;
    wraps_d = wraps_q;
    if (ctl_io.clear) begin
      state_d = ST_IDLE;
      count_d = {WIDTH{1'b0}};
      limit_d = {WIDTH{1'b0}};
      wrap_d  = 1'b0;
      wraps_d = {WRAP_W{1'b0}};
    end else if (ctl_io.start) begin
      state_d = ST_RUN;
      count_d = {WIDTH{1'b0}};
      limit_d = ctl_io.limit;
      wrap_d  = ctl_io.wrap_mode;
      wraps_d = {WRAP_W{1'b0}};
    end else begin
      case (state_q)
        ST_RUN: begin
          if (ctl_io.enable) begin
            if (count_q != limit_q) begin
              count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
            end else if (wrap_q) begin
              count_d = {WIDTH{1'b0}};
              if (wraps_q != {WRAP_W{1'b1}}) begin
                wraps_d = wraps_q + {{(WRAP_W-1){1'b0}}, 1'b1};
              end else begin
                wraps_d = wraps_q;
              end
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_IDLE: state_d = ST_IDLE;
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // DONE is only reachable from RUN, so this is a single-cycle entry pulse.
  always_comb begin
    busy_d = (state_d == ST_RUN);
    done_d = (state_q == ST_RUN) && (state_d == ST_DONE);
  end

  // State, configuration and registered outputs.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= ST_IDLE;
      count_q  <= {WIDTH{1'b0}};
      limit_q  <= {WIDTH{1'b0}};
      wrap_q   <= 1'b0;
      wraps_q  <= {WRAP_W{1'b0}};
      bucket_q <= {IDX_W{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      limit_q  <= limit_d;
      wrap_q   <= wrap_d;
      wraps_q  <= wraps_d;
      bucket_q <= bucket_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign ctl_io.count  = count_q;
  assign ctl_io.bucket = bucket_q;
  assign ctl_io.busy   = busy_q;
  assign ctl_io.done   = done_q;
  assign ctl_io.wraps  = wraps_q;

endmodule
